// File: rtl/shadow_stack_unit_pkg.sv
// Shared types for the shadow-stack unit: operation codes, FSM states and slot size.
package shadow_stack_unit_pkg;

  localparam int XLEN          = 64;
  localparam int SS_SLOT_BYTES = XLEN / 8;

  typedef enum logic [1:0] {
    SS_PUSH   = 2'd0,
    SS_POPCHK = 2'd1,
    SS_WRSSP  = 2'd2
  } ss_op_t;

  typedef enum logic [2:0] {
    SS_IDLE,
    SS_PUSH_REQ,
    SS_POP_REQ,
    SS_WAIT_RSP,
    SS_DRAIN
  } ss_state_e;

endpackage

// File: rtl/shadow_stack_unit.sv
// Shadow-stack pointer owner: executes SSPUSH / SSPOPCHK against the data cache,
// SSP writes, and ALU SSPINC writebacks.
module shadow_stack_unit
  import shadow_stack_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] SSP_RST_VAL = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            xBCFIE_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  ss_op_t          op_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] ssp_o,
  input  logic            alu_ssp_we_i,
  input  logic [XLEN-1:0] alu_ssp_i,
  output logic            done_o,
  output logic            fault_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_err_i
);

  localparam logic [XLEN-1:0] XLEN_BYTES = XLEN'(SS_SLOT_BYTES);

  ss_state_e       state_q, state_d;
  logic [XLEN-1:0] ssp_q, addr_q, addr_d, data_q, data_d, unit_ssp_d;
  logic            is_pop_q, is_pop_d, unit_ssp_we;
  logic            done_q, done_d, fault_q, fault_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_pop_d    = is_pop_q;
    unit_ssp_we = 1'b0;
    unit_ssp_d  = ssp_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    case (state_q)
      SS_IDLE: if (valid_i) begin
        data_d = data_i;
        case (op_i)
          SS_WRSSP: begin
            unit_ssp_we = 1'b1;
            unit_ssp_d  = data_i;
            done_d      = 1'b1;
          end
          SS_PUSH: if (xBCFIE_i) begin
            addr_d   = ssp_q - XLEN_BYTES;
            is_pop_d = 1'b0;
            state_d  = SS_PUSH_REQ;
          end else done_d = 1'b1;
          SS_POPCHK: if (xBCFIE_i) begin
            addr_d   = ssp_q;
            is_pop_d = 1'b1;
            state_d  = SS_POP_REQ;
          end else done_d = 1'b1;
          default: done_d = 1'b1;
        endcase
      end
      SS_PUSH_REQ, SS_POP_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = (state_q == SS_PUSH_REQ);
        // A flush racing the grant still owes us one response, so drain it.
        if (mem_gnt_i)    state_d = flush_i ? SS_DRAIN : SS_WAIT_RSP;
        else if (flush_i) state_d = SS_IDLE;
      end
      SS_WAIT_RSP: begin
        if (mem_rvalid_i) begin
          state_d = SS_IDLE;
          if (!flush_i) begin
            done_d = 1'b1;
            if (is_pop_q) begin
              if (!mem_err_i && mem_rdata_i == data_q) begin
                unit_ssp_we = 1'b1;
                unit_ssp_d  = ssp_q + XLEN_BYTES;
              end else fault_d = 1'b1;
            end else if (!mem_err_i) begin
              unit_ssp_we = 1'b1;
              unit_ssp_d  = addr_q;
            end else fault_d = 1'b1;
          end
        end else if (flush_i) state_d = SS_DRAIN;
      end
      SS_DRAIN: if (mem_rvalid_i) state_d = SS_IDLE;
      default:  state_d = SS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SS_IDLE;
      ssp_q    <= SSP_RST_VAL;
      addr_q   <= '0;
      data_q   <= '0;
      is_pop_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      is_pop_q <= is_pop_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      // The unit's own SSP write wins over a simultaneous ALU writeback.
      if (unit_ssp_we)       ssp_q <= unit_ssp_d;
      else if (alu_ssp_we_i) ssp_q <= alu_ssp_i;
    end
  end

  assign ready_o     = (state_q == SS_IDLE);
  assign ssp_o       = ssp_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = data_q;

  a_no_alu_ssp_in_flight: assert property (
    @(posedge clk_i) disable iff (rst_i) !(alu_ssp_we_i && state_q != SS_IDLE));

endmodule

// File: tb/tb_shadow_stack_unit.sv
// Randomized scoreboard bench for shadow_stack_unit with a behavioural SSP/memory model.
module tb_shadow_stack_unit;
  import shadow_stack_unit_pkg::*;

  localparam logic [63:0] RST_VAL = 64'h8000_1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0, xBCFIE_i = 1'b1, valid_i = 1'b0;
  logic        ready_o;
  ss_op_t      op_i = SS_PUSH;
  logic [63:0] data_i = '0, ssp_o, alu_ssp_i = '0;
  logic        alu_ssp_we_i = 1'b0;
  logic        done_o, fault_o, mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;

  always #5 clk_i = ~clk_i;

  shadow_stack_unit #(.SSP_RST_VAL(RST_VAL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .xBCFIE_i(xBCFIE_i),
    .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i), .data_i(data_i),
    .ssp_o(ssp_o), .alu_ssp_we_i(alu_ssp_we_i), .alu_ssp_i(alu_ssp_i),
    .done_o(done_o), .fault_o(fault_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  typedef struct packed {logic fault; logic [63:0] ssp;} exp_t;

  int          checks = 0, failures = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] ssp_m;
  logic [63:0] mem_m [logic [63:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_done(input logic fault, input logic [63:0] ssp);
    exp_t e;
    e.fault = fault;
    e.ssp   = ssp;
    exp_q.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("done_fault", {63'd0, fault_o}, {63'd0, mon_e.fault});
        check("done_ssp", ssp_o, mon_e.ssp);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("ready_timeout", {63'd0, ready_o}, 64'd1);
  endtask

  // Issues one operation and plays the memory side. flush_at counts cycles after acceptance.
  task automatic run_op(input ss_op_t op, input logic [63:0] data, input logic bcfie,
                        input logic err, input int gdly, input int rdly, input int flush_at,
                        input logic [63:0] rdata);
    logic [63:0] exp_addr;
    bit          memop, flushed, drained;
    int          k;
    wait_ready();
    exp_addr = (op == SS_PUSH) ? ssp_m - 64'd8 : ssp_m;
    memop    = bcfie && (op == SS_PUSH || op == SS_POPCHK);
    valid_i  = 1'b1; op_i = op; data_i = data; xBCFIE_i = bcfie;
    if (!memop) begin
      if (op == SS_WRSSP) ssp_m = data;
      expect_done(1'b0, ssp_m);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("noop_no_req", {63'd0, mem_req_o}, 64'd0);
      return;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    flushed = 0; drained = 0; k = 0;
    for (int c = 0; c <= gdly; c++) begin
      mem_gnt_i = (c == gdly);
      flush_i   = (c == flush_at);
      @(negedge clk_i);
      check("req", {63'd0, mem_req_o}, 64'd1);
      check("req_we", {63'd0, mem_we_o}, {63'd0, op == SS_PUSH});
      check("req_addr", mem_addr_o, exp_addr);
      if (op == SS_PUSH) check("req_wdata", mem_wdata_o, data);
      @(posedge clk_i); #1;
      if (flush_i) begin flushed = 1; drained = (c == gdly); end
      flush_i = 1'b0; mem_gnt_i = 1'b0; k++;
      if (flushed) break;
    end
    if (flushed && !drained) begin
      check("drop_ready", {63'd0, ready_o}, 64'd1);
      check("drop_req", {63'd0, mem_req_o}, 64'd0);
      check("drop_ssp", ssp_o, ssp_m);
      return;
    end
    if (op == SS_PUSH && !err) mem_m[exp_addr] = data;
    for (int c = 0; c <= rdly; c++) begin
      mem_rvalid_i = (c == rdly);
      mem_rdata_i  = (c == rdly) ? rdata : {$urandom, $urandom};
      mem_err_i    = (c == rdly) ? err : 1'($urandom);
      if (!flushed && k == flush_at) begin flush_i = 1'b1; flushed = 1; end
      if (c == rdly && !flushed) begin
        if (op == SS_PUSH) begin
          if (err) expect_done(1'b1, ssp_m);
          else begin ssp_m = ssp_m - 64'd8; expect_done(1'b0, ssp_m); end
        end else begin
          if (!err && rdata == data) begin ssp_m = ssp_m + 64'd8; expect_done(1'b0, ssp_m); end
          else expect_done(1'b1, ssp_m);
        end
      end
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0; mem_err_i = 1'b0; flush_i = 1'b0; k++;
    end
    if (flushed) begin
      check("drain_ready", {63'd0, ready_o}, 64'd1);
      check("drain_ssp", ssp_o, ssp_m);
    end
  endtask

  task automatic alu_write(input logic [63:0] v);
    wait_ready();
    alu_ssp_we_i = 1'b1; alu_ssp_i = v; ssp_m = v;
    @(posedge clk_i); #1;
    alu_ssp_we_i = 1'b0;
    check("alu_ssp", ssp_o, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d, rd, addr;
    ss_op_t      op;
    int          gd, rdl, fa;
    ssp_m = RST_VAL;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_ssp", ssp_o, RST_VAL);
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_addr", mem_addr_o, 64'd0);
    check("rst_wdata", mem_wdata_o, 64'd0);

    run_op(SS_PUSH,   64'hDEAD_BEEF, 1'b1, 1'b0, 0, 0, -1, 64'd0);
    run_op(SS_POPCHK, 64'hDEAD_BEEF, 1'b1, 1'b0, 0, 0, -1, 64'hDEAD_BEEF);
    run_op(SS_POPCHK, 64'hDEAD_BEEF, 1'b1, 1'b0, 0, 0, -1, 64'h1234);
    run_op(SS_PUSH,   64'h55,        1'b1, 1'b1, 1, 1, -1, 64'd0);
    run_op(SS_PUSH,   64'h77,        1'b0, 1'b0, 0, 0, -1, 64'd0);
    run_op(SS_WRSSP,  64'h10,        1'b1, 1'b0, 0, 0, -1, 64'd0);
    run_op(SS_PUSH,   64'h99,        1'b1, 1'b0, 3, 0,  2, 64'd0);
    run_op(SS_PUSH,   64'h99,        1'b1, 1'b0, 0, 2,  1, 64'd0);
    run_op(SS_PUSH,   64'h99,        1'b1, 1'b0, 1, 1,  1, 64'd0);
    run_op(SS_WRSSP,  64'h0,         1'b1, 1'b0, 0, 0, -1, 64'd0);
    run_op(SS_PUSH,   64'hABCD,      1'b1, 1'b0, 0, 0, -1, 64'd0);
    alu_write(64'h2000);

    // SSP write by the unit and ALU writeback in the same cycle.
    wait_ready();
    valid_i = 1'b1; op_i = SS_WRSSP; data_i = 64'h3000; xBCFIE_i = 1'b1;
    alu_ssp_we_i = 1'b1; alu_ssp_i = 64'h5555;
    ssp_m = 64'h3000; expect_done(1'b0, ssp_m);
    @(posedge clk_i); #1;
    valid_i = 1'b0; alu_ssp_we_i = 1'b0;
    check("wrssp_beats_alu", ssp_o, 64'h3000);

    // Reset with a response outstanding; the late rvalid must be ignored.
    wait_ready();
    valid_i = 1'b1; op_i = SS_PUSH; data_i = 64'h42; xBCFIE_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; ssp_m = RST_VAL;
    check("mid_rst_ssp", ssp_o, RST_VAL);
    check("mid_rst_req", {63'd0, mem_req_o}, 64'd0);
    check("mid_rst_addr", mem_addr_o, 64'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h42;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    check("idle_rvalid_ready", {63'd0, ready_o}, 64'd1);
    check("idle_rvalid_ssp", ssp_o, ssp_m);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) alu_write({$urandom, $urandom_range(0, 255), 3'b000});
      case ($urandom_range(0, 4))
        0, 1:    op = SS_PUSH;
        2, 3:    op = SS_POPCHK;
        default: op = SS_WRSSP;
      endcase
      gd   = $urandom_range(0, 3);
      rdl  = $urandom_range(0, 3);
      fa   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, gd + rdl) : -1;
      addr = ssp_m;
      rd   = mem_m.exists(addr) ? mem_m[addr] : {$urandom, $urandom};
      if (op == SS_POPCHK) d = ($urandom_range(0, 3) != 0) ? rd : rd ^ {32'd0, $urandom | 32'd1};
      else if (op == SS_WRSSP) d = {$urandom, $urandom_range(0, 255), 3'b000};
      else d = {$urandom, $urandom};
      run_op(op, d, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, gd, rdl, fa, rd);
    end

    repeat (3) @(posedge clk_i);
    #1 check("pending_done", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
